// File: rtl/dev_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dev_bridge
// Purpose  : CPU data-port bridge. Decodes M-stage accesses onto the data
//            memory (DM), NUM_TC timer channels, the interrupt generator (INT)
//            and a small local register block (BR). BR holds interrupt
//            pending/mask state and an unmapped-access error log.
// Config   : `define DEV_BRIDGE_IRQ_LATCH_EN -> PEND latches rising edges of
//            the IRQ sources (RW1C). When undefined, PEND reads the raw sources
//            and HWInt = src & MASK.
// Ports    : clk, reset                    - clock, sync active-high reset
//            cpu_m_data_* / cpu_m_inst_addr - CPU M-stage bus (in), rdata (out)
//            dm_m_data_* / dm_m_inst_addr   - data-memory side
//            m_int_addr, m_int_byteen       - interrupt generator side
//            tc_addr/tc_we/tc_wdata/tc_rdata/tc_irq - timer channels
//            ext_irq                        - external IRQ lines
//            HWInt                          - masked pending IRQs to the CPU
//            bus_err                        - one-cycle pulse after unmapped access
// BR map   : +0x0 PEND, +0x4 MASK, +0x8 ERR_ADDR (RO), +0xC ERR_CNT
// Revision : 1.0 - initial release
// ============================================================================
module dev_bridge #(
  parameter int          NUM_TC   = 2,
  parameter int          NUM_EXT  = 1,
  parameter logic [31:0] TC_BASE  = 32'h00007f00,
  parameter logic [31:0] DM_LIMIT = 32'h00002fff,
  parameter logic [31:0] INT_ADDR = 32'h00007f20,
  parameter logic [31:0] BR_BASE  = 32'h00007f30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            cpu_m_data_addr,
  input  logic [31:0]            cpu_m_data_wdata,
  input  logic [3:0]             cpu_m_data_byteen,
  input  logic                   cpu_m_data_re,
  input  logic [31:0]            cpu_m_inst_addr,
  output logic [31:0]            cpu_m_data_rdata,
  output logic [31:0]            dm_m_data_addr,
  output logic [31:0]            dm_m_data_wdata,
  output logic [3:0]             dm_m_data_byteen,
  output logic [31:0]            dm_m_inst_addr,
  input  logic [31:0]            dm_m_data_rdata,
  output logic [31:0]            m_int_addr,
  output logic [3:0]             m_int_byteen,
  output logic [NUM_TC*30-1:0]   tc_addr,
  output logic [NUM_TC-1:0]      tc_we,
  output logic [31:0]            tc_wdata,
  input  logic [NUM_TC*32-1:0]   tc_rdata,
  input  logic [NUM_TC-1:0]      tc_irq,
  input  logic [NUM_EXT-1:0]     ext_irq,
  output logic [5:0]             HWInt,
  output logic                   bus_err
);

  localparam int         NSRC    = NUM_TC + NUM_EXT;
  // Bits of PEND/MASK that correspond to a real source.
  localparam logic [5:0] C_VALID = 6'h3f >> (6 - NSRC);

  logic [31:0]       addr;
  logic [1:0]        off;
  logic              sel_dm, sel_int, sel_br, any_sel;
  logic [NUM_TC-1:0] sel_tc;
  logic              access, wr_full, unmapped, br_wr;
  logic [5:0]        src, pend;

  logic [5:0]        r_mask;
  logic [31:0]       r_err_addr;
  logic [15:0]       r_err_cnt;
  logic              r_bus_err;

  assign addr    = cpu_m_data_addr;
  assign off     = addr[3:2];
  assign wr_full = (cpu_m_data_byteen == 4'b1111);
  assign access  = cpu_m_data_re | (|cpu_m_data_byteen);

  // Region decode; regions are disjoint so at most one select is active.
  assign sel_dm  = (addr <= DM_LIMIT);
  assign sel_int = (addr >= INT_ADDR) && (addr <= INT_ADDR + 32'd3);
  assign sel_br  = (addr >= BR_BASE)  && (addr <= BR_BASE + 32'd15);

  genvar g;
  generate
    for (g = 0; g < NUM_TC; g++) begin : g_tc
      localparam logic [31:0] C_BASE = TC_BASE + 32'(16 * g);
      // Only offsets 0x0..0x8 belong to a timer; 0xC falls through as unmapped.
      assign sel_tc[g]            = (addr >= C_BASE) && (addr <= C_BASE + 32'd11);
      assign tc_addr[g*30 +: 30]  = {28'b0, addr[3:2]};
      assign tc_we[g]             = sel_tc[g] & wr_full;
    end
  endgenerate

  assign any_sel  = sel_dm | sel_int | sel_br | (|sel_tc);
  assign unmapped = access & ~any_sel;
  assign br_wr    = sel_br & wr_full;

  // Pass-through paths
  assign dm_m_data_addr   = cpu_m_data_addr;
  assign dm_m_data_wdata  = cpu_m_data_wdata;
  assign dm_m_inst_addr   = cpu_m_inst_addr;
  assign dm_m_data_byteen = sel_dm ? cpu_m_data_byteen : 4'b0000;
  assign m_int_addr       = cpu_m_data_addr;
  assign m_int_byteen     = sel_int ? cpu_m_data_byteen : 4'b0000;
  assign tc_wdata         = cpu_m_data_wdata;

  // IRQ source vector: timers in the low bits, external lines above them.
  always_comb begin
    src                  = 6'b0;
    src[NUM_TC-1:0]      = tc_irq;
    src[NSRC-1:NUM_TC]   = ext_irq;
  end

`ifdef DEV_BRIDGE_IRQ_LATCH_EN
  logic [5:0] r_pend, r_src_q, rise, w1c;
  logic       r_hist_vld;

  // Edge detection is suppressed for the first cycle after reset so that a
  // source already high at release is not mistaken for a new edge.
  assign rise = r_hist_vld ? (src & ~r_src_q) : 6'b0;
  assign w1c  = (br_wr && (off == 2'd0)) ? cpu_m_data_wdata[5:0] : 6'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= 6'b0;
      r_src_q    <= 6'b0;
      r_hist_vld <= 1'b0;
    end else begin
      // A new edge wins over a simultaneous clear of the same bit.
      r_pend     <= ((r_pend & ~w1c) | rise) & C_VALID;
      r_src_q    <= src;
      r_hist_vld <= 1'b1;
    end
  end

  assign pend = r_pend;
`else
  assign pend = src;
`endif

  assign HWInt   = pend & r_mask;
  assign bus_err = r_bus_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask     <= C_VALID;
      r_err_addr <= 32'h0;
      r_err_cnt  <= 16'h0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= unmapped;
      if (unmapped)
        r_err_addr <= addr;
      if (br_wr && (off == 2'd1))
        r_mask <= cpu_m_data_wdata[5:0] & C_VALID;
      if (br_wr && (off == 2'd3))
        r_err_cnt <= 16'h0;
      else if (unmapped && (r_err_cnt != 16'hffff))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  // Read mux; INT and unmapped addresses return zero.
  always_comb begin
    cpu_m_data_rdata = 32'h0;
    if (sel_dm) begin
      cpu_m_data_rdata = dm_m_data_rdata;
    end else if (sel_br) begin
      case (off)
        2'd0:    cpu_m_data_rdata = {26'b0, pend};
        2'd1:    cpu_m_data_rdata = {26'b0, r_mask};
        2'd2:    cpu_m_data_rdata = r_err_addr;
        default: cpu_m_data_rdata = {16'b0, r_err_cnt};
      endcase
    end else begin
      for (int i = 0; i < NUM_TC; i++)
        if (sel_tc[i]) cpu_m_data_rdata = tc_rdata[i*32 +: 32];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dev_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dev_bridge
// Purpose  : Self-checking bench for dev_bridge (default parameters).
//            Decode/mux behaviour comes from a vector table; bus_err
//            expectations queue up as each vector is driven and are
//            consumed one clock later. IRQ and error-counter corner cases
//            use hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dev_bridge;

  localparam logic [31:0] BR = 32'h00007f30;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_m_data_addr, cpu_m_data_wdata, cpu_m_inst_addr, cpu_m_data_rdata;
  logic [3:0]  cpu_m_data_byteen;
  logic        cpu_m_data_re;
  logic [31:0] dm_m_data_addr, dm_m_data_wdata, dm_m_inst_addr, dm_m_data_rdata;
  logic [3:0]  dm_m_data_byteen;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic [59:0] tc_addr;
  logic [1:0]  tc_we;
  logic [31:0] tc_wdata;
  logic [63:0] tc_rdata;
  logic [1:0]  tc_irq;
  logic [0:0]  ext_irq;
  logic [5:0]  HWInt;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dev_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_m_data_addr(cpu_m_data_addr), .cpu_m_data_wdata(cpu_m_data_wdata),
    .cpu_m_data_byteen(cpu_m_data_byteen), .cpu_m_data_re(cpu_m_data_re),
    .cpu_m_inst_addr(cpu_m_inst_addr), .cpu_m_data_rdata(cpu_m_data_rdata),
    .dm_m_data_addr(dm_m_data_addr), .dm_m_data_wdata(dm_m_data_wdata),
    .dm_m_data_byteen(dm_m_data_byteen), .dm_m_inst_addr(dm_m_inst_addr),
    .dm_m_data_rdata(dm_m_data_rdata),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .tc_addr(tc_addr), .tc_we(tc_we), .tc_wdata(tc_wdata), .tc_rdata(tc_rdata),
    .tc_irq(tc_irq), .ext_irq(ext_irq), .HWInt(HWInt), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        re;
    logic [31:0] rdata;
    logic [3:0]  dm_be;
    logic [3:0]  int_be;
    logic [1:0]  we;
    logic [1:0]  tca;
    logic        err;
  } vec_t;

  vec_t vecs[13];
  logic q_err[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    cpu_m_data_addr   = 32'h0;
    cpu_m_data_wdata  = 32'h0;
    cpu_m_data_byteen = 4'h0;
    cpu_m_data_re     = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    cpu_m_data_addr = a; cpu_m_data_wdata = d; cpu_m_data_byteen = be; cpu_m_data_re = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    cpu_m_data_addr = a; cpu_m_data_byteen = 4'h0; cpu_m_data_re = 1'b1;
    #1 chk(name, cpu_m_data_rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // addr, wdata, be, re, rdata, dm_be, int_be, we, tca, err
    vecs[0]  = '{32'h7f14, 32'h5,        4'hf, 1'b0, 32'hbbbb0001, 4'h0, 4'h0, 2'b10, 2'd1, 1'b0};
    vecs[1]  = '{32'h7f14, 32'h5,        4'h1, 1'b0, 32'hbbbb0001, 4'h0, 4'h0, 2'b00, 2'd1, 1'b0};
    vecs[2]  = '{32'h7f00, 32'h0,        4'h0, 1'b1, 32'haaaa0000, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0};
    vecs[3]  = '{32'h4000, 32'h0,        4'h0, 1'b1, 32'h0,        4'h0, 4'h0, 2'b00, 2'd0, 1'b1};
    vecs[4]  = '{32'h3000, 32'h0,        4'h0, 1'b1, 32'h0,        4'h0, 4'h0, 2'b00, 2'd0, 1'b1};
    vecs[5]  = '{32'h7f0c, 32'h0,        4'h0, 1'b1, 32'h0,        4'h0, 4'h0, 2'b00, 2'd3, 1'b1};
    vecs[6]  = '{32'h2ffc, 32'hcafef00d, 4'hf, 1'b0, 32'hd00dfeed, 4'hf, 4'h0, 2'b00, 2'd3, 1'b0};
    vecs[7]  = '{32'h7f20, 32'h1,        4'hf, 1'b0, 32'h0,        4'h0, 4'hf, 2'b00, 2'd0, 1'b0};
    vecs[8]  = '{32'h7f23, 32'h1,        4'h8, 1'b0, 32'h0,        4'h0, 4'h8, 2'b00, 2'd0, 1'b0};
    vecs[9]  = '{32'h5000, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 4'h0, 2'b00, 2'd0, 1'b0};
    vecs[10] = '{32'h0000, 32'h0,        4'h0, 1'b1, 32'hd00dfeed, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0};
    vecs[11] = '{32'h7f24, 32'h0,        4'h0, 1'b1, 32'h0,        4'h0, 4'h0, 2'b00, 2'd1, 1'b1};
    vecs[12] = '{32'h7f18, 32'h0,        4'h0, 1'b1, 32'hbbbb0001, 4'h0, 4'h0, 2'b00, 2'd2, 1'b0};

    idle();
    cpu_m_inst_addr = 32'h0;
    tc_irq = 2'b00;
    ext_irq = 1'b0;
    tc_rdata = {32'hbbbb0001, 32'haaaa0000};
    dm_m_data_rdata = 32'hd00dfeed;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_hwint", HWInt, 6'h0);
    rdchk("rst_pend", BR, 32'h0);
    rdchk("rst_mask", BR + 32'h4, 32'h7);
    rdchk("rst_err_addr", BR + 32'h8, 32'h0);
    rdchk("rst_err_cnt", BR + 32'hc, 32'h0);

    // Decode / mux table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      cpu_m_data_addr   = vecs[i].addr;
      cpu_m_data_wdata  = vecs[i].wdata;
      cpu_m_data_byteen = vecs[i].be;
      cpu_m_data_re     = vecs[i].re;
      cpu_m_inst_addr   = 32'h1000_0000 + 32'(i);
      #1;
      chk($sformatf("v%0d_rdata", i), cpu_m_data_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_dm_be", i), dm_m_data_byteen, vecs[i].dm_be);
      chk($sformatf("v%0d_int_be", i), m_int_byteen, vecs[i].int_be);
      chk($sformatf("v%0d_tc_we", i), tc_we, vecs[i].we);
      chk($sformatf("v%0d_tc_addr", i), tc_addr, {28'b0, vecs[i].tca, 28'b0, vecs[i].tca});
      chk($sformatf("v%0d_tc_wdata", i), tc_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_dm_addr", i), dm_m_data_addr, vecs[i].addr);
      chk($sformatf("v%0d_int_addr", i), m_int_addr, vecs[i].addr);
      chk($sformatf("v%0d_inst_addr", i), dm_m_inst_addr, 32'h1000_0000 + 32'(i));
      q_err.push_back(vecs[i].err);
      @(posedge clk);
      #1 chk($sformatf("v%0d_bus_err", i), bus_err, q_err.pop_front());
    end
    rdchk("err_addr_last", BR + 32'h8, 32'h7f24);
    rdchk("err_cnt_4", BR + 32'hc, 32'h4);

`ifdef DEV_BRIDGE_IRQ_LATCH_EN
    // One-cycle pulse latches and holds
    @(negedge clk) tc_irq = 2'b01;
    @(negedge clk) tc_irq = 2'b00;
    #1 chk("pulse_hwint", HWInt, 6'h01);
    repeat (3) @(negedge clk);
    #1 chk("pulse_hold", HWInt, 6'h01);
    wr(BR, 32'h1, 4'hf);
    #1 chk("w1c_clear", HWInt, 6'h00);
    // New edge together with W1C: set wins
    @(negedge clk);
    cpu_m_data_addr = BR; cpu_m_data_wdata = 32'h1; cpu_m_data_byteen = 4'hf;
    tc_irq = 2'b01;
    @(negedge clk);
    idle(); tc_irq = 2'b00;
    #1 chk("set_wins", HWInt, 6'h01);
    wr(BR, 32'h1, 4'hf);
    #1 chk("w1c_clear2", HWInt, 6'h00);
    // Masked pending
    wr(BR + 32'h4, 32'h0, 4'hf);
    @(negedge clk) ext_irq = 1'b1;
    @(negedge clk) ext_irq = 1'b0;
    rdchk("pend_ext", BR, 32'h4);
    chk("masked_hwint", HWInt, 6'h00);
    wr(BR + 32'h4, 32'h4, 4'hf);
    #1 chk("unmask_hwint", HWInt, 6'h04);
    wr(BR, 32'h4, 4'hf);
    #1 chk("w1c_ext", HWInt, 6'h00);
`else
    // Raw mode: PEND follows sources, W1C has no effect
    @(negedge clk) tc_irq = 2'b01;
    #1 chk("raw_hwint", HWInt, 6'h01);
    rdchk("raw_pend", BR, 32'h1);
    wr(BR, 32'h1, 4'hf);
    rdchk("raw_w1c_ignored", BR, 32'h1);
    wr(BR + 32'h4, 32'h0, 4'hf);
    #1 chk("raw_masked", HWInt, 6'h00);
    ext_irq = 1'b1;
    rdchk("raw_pend_both", BR, 32'h5);
    chk("raw_masked2", HWInt, 6'h00);
    wr(BR + 32'h4, 32'h4, 4'hf);
    #1 chk("raw_unmask", HWInt, 6'h04);
    tc_irq = 2'b00; ext_irq = 1'b0;
    #1 chk("raw_src_low", HWInt, 6'h00);
`endif

    // MASK only keeps valid bits
    wr(BR + 32'h4, 32'hffffffff, 4'hf);
    rdchk("mask_valid_bits", BR + 32'h4, 32'h7);
    wr(BR + 32'h4, 32'h0, 4'hf);

    // Reset overrides a simultaneous write; source high through reset
    @(negedge clk);
    cpu_m_data_addr = BR + 32'h4; cpu_m_data_wdata = 32'h0; cpu_m_data_byteen = 4'hf;
    tc_irq = 2'b01;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) begin reset = 1'b0; idle(); end
    #1 chk("post_rst_bus_err", bus_err, 1'b0);
    rdchk("post_rst_mask", BR + 32'h4, 32'h7);
    rdchk("post_rst_err_cnt", BR + 32'hc, 32'h0);
    repeat (2) @(negedge clk);
`ifdef DEV_BRIDGE_IRQ_LATCH_EN
    rdchk("high_at_release", BR, 32'h0);
    chk("high_at_release_hw", HWInt, 6'h00);
    @(negedge clk) tc_irq = 2'b00;
    @(negedge clk) tc_irq = 2'b01;
    rdchk("re_rise", BR, 32'h1);
    tc_irq = 2'b00;
    wr(BR, 32'h1, 4'hf);
`else
    rdchk("raw_pend_high", BR, 32'h1);
    tc_irq = 2'b00;
`endif

    // Error counter saturation
    @(negedge clk);
    idle();
    cpu_m_data_addr = 32'h4000; cpu_m_data_re = 1'b1;
    @(posedge clk);
    #1 chk("sat_bus_err", bus_err, 1'b1);
    repeat (65534) @(posedge clk);
    @(negedge clk) idle();
    #1 chk("sat_bus_err_hold", bus_err, 1'b1);
    rdchk("err_cnt_ffff", BR + 32'hc, 32'hffff);
    chk("bus_err_drop", bus_err, 1'b0);
    @(negedge clk);
    cpu_m_data_addr = 32'h4000; cpu_m_data_re = 1'b1;
    @(posedge clk);
    #1 chk("single_err_pulse", bus_err, 1'b1);
    rdchk("err_cnt_sat", BR + 32'hc, 32'hffff);
    rdchk("err_addr_4000", BR + 32'h8, 32'h4000);
    #6 chk("single_err_end", bus_err, 1'b0);
    wr(BR + 32'hc, 32'h1234, 4'hf);
    rdchk("err_cnt_clear", BR + 32'hc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
